register_pipe: RTL and testbench
================================

# register_pipe

Parametrised elastic pipeline register with a valid/ready handshake on both sides. It chains DEPTH skid-buffered stages, so a full-throughput pipeline boundary can stall without a combinational ready path. It also supports a synchronous flush and reports its occupancy. It replaces plain enable registers wherever the RISC-V core, or trace logic, needs backpressure between producer and consumer.

## Interface
- DATA_WIDTH, 64, payload width in bits (≥1)
- DEPTH, 2, number of chained stages (≥1); total capacity 2*DEPTH entries
- CNT_WIDTH, $clog2(2*DEPTH+1), width of o_count (localparam, not overridable)

- i_clk  in  1  clock, rising edge
- i_arst  in  1  reset, asynchronous, active-high
- i_flush  in  1  synchronous flush, discards all held entries
- i_valid  in  1  upstream offers i_data
- o_ready  out  1  pipeline accepts i_data this cycle; registered
- i_data  in  DATA_WIDTH  upstream payload
- o_valid  out  1  o_data holds a valid entry
- i_ready  in  1  downstream accepts o_data this cycle
- o_data  out  DATA_WIDTH  head payload
- o_count  out  CNT_WIDTH  number of valid entries held
- o_parity_err  out  1  head entry parity mismatch; tied 0 unless the parity feature is compiled in

## Operation
- Each stage holds two registers, main and skid, each with a valid bit.
  - Stage out_valid = main_valid.
  - Stage in_ready = !skid_valid, read directly from a flop.
- The stage accepts an entry when in_valid & in_ready:
  - Main empty, or main drains this cycle (main_valid & out_ready): entry goes to main.
  - Otherwise: entry goes to skid.
- When main drains and skid_valid is set, skid moves to main and skid_valid clears in the same edge.
- Stages are chained: stage k output feeds stage k+1 input. o_ready is the ready of stage 0; o_valid and o_data come from the main register of stage DEPTH-1.
- Ordering is strict FIFO. No entry is ever dropped or duplicated except by flush.
- o_count:
  - +1 on an input handshake (i_valid & o_ready).
  - −1 on an output handshake (o_valid & i_ready).
  - Unchanged when both or neither occur.
  - Never exceeds 2*DEPTH and never underflows.
- Flush:
  - Clears every valid bit and sets o_count to 0 on the next edge. Data registers keep their contents.
  - Flush dominates a same-cycle input handshake: that entry is discarded.
  - An output handshake in the flush cycle still completes.
- Reset values:
  - All valid bits 0, o_valid 0.
  - o_ready 1.
  - o_data all zeros; all data registers reset to 0.
  - o_count 0, o_parity_err 0.
- Reset asserted mid-transfer discards all entries immediately (asynchronous). No handshake completes while i_arst is high.

## Timing
- Latency: an entry accepted at edge N is presented on o_valid after edge N+DEPTH−1, i.e. in cycle N+DEPTH−1+1 relative to acceptance, when no stall occurs. For DEPTH=1 it is visible the cycle after acceptance.
- Throughput: one entry per cycle sustained while i_ready stays high.
- When i_ready drops, o_ready falls after at most two further accepted entries per stage boundary. Capacity is exactly 2*DEPTH.
- No combinational path from i_ready to o_ready, or from i_valid to o_valid. o_parity_err is combinational from head registers only.

## Configuration
- REGISTER_PIPE_PARITY_EN defined:
  - Every entry carries one extra even-parity bit, computed as ^i_data at acceptance and moved with the entry.
  - o_parity_err = o_valid & (^o_data ^ head_parity).
- Not defined: no parity storage, and o_parity_err is constant 0. The port list is identical in both builds.

## Structure
- Shared package register_pipe_pkg: a count-width helper function and a parity helper function. Widths stay module parameters.
- One sub-module, register_skid: a single two-entry stage with in/out valid/ready, flush, parity bit (conditional), and an out-handshake pulse.
- register_pipe instantiates DEPTH register_skid instances in a generate loop and holds the o_count counter.

## Test plan
- Reset, then idle: o_ready=1, o_valid=0, o_data=0, o_count=0.
- DEPTH=2, stream 0x1..0x10 with i_ready=1 → outputs arrive in order, one per cycle, with the first output DEPTH cycles after the first accept; o_count stays ≤2.
- DEPTH=2, i_ready=0, push continuously → exactly 4 entries accepted, o_ready=0, o_count=4; raise i_ready → 4 entries out in order, o_count returns to 0.
- Random i_valid/i_ready toggling over 10k cycles against a scoreboard queue → no loss, reorder or duplication; o_count matches the model every cycle.
- Fill 3 entries, then assert i_flush together with i_valid → next cycle o_valid=0, o_count=0; entry 0xAA pushed afterwards is the next output.
- With REGISTER_PIPE_PARITY_EN defined, force one bit of the head data register → o_parity_err=1 while o_valid=1; without the macro, o_parity_err stays 0.

Source files
------------

// File: rtl/register_pipe_pkg.sv
// Shared helpers for the register_pipe elastic pipeline.
// REGISTER_PIPE_PARITY_EN adds one even-parity bit to every stored entry.
package register_pipe_pkg;

  // Upper bound on payload width the parity helper can reduce.
  localparam int unsigned PARITY_MAX_W = 1024;

`ifdef REGISTER_PIPE_PARITY_EN
  localparam int unsigned PARITY_W = 1;
`else
  localparam int unsigned PARITY_W = 0;
`endif

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

  // Callers zero-extend narrower payloads, which leaves the parity unchanged.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/register_skid.sv
// One two-entry skid stage: main register feeds the output, skid absorbs one
// extra entry so in_ready_o comes straight from a flop. Parity via REGISTER_PIPE_PARITY_EN.
module register_skid
  import register_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
`ifdef REGISTER_PIPE_PARITY_EN
  input  logic                  in_par_i,
  output logic                  out_par_o,
`endif
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_hs_o
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + PARITY_W;

  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic [ENTRY_W-1:0] in_entry;
  logic               in_hs;
  logic               out_hs;

`ifdef REGISTER_PIPE_PARITY_EN
  assign in_entry  = {in_par_i, in_data_i};
  assign out_par_o = main_q[DATA_WIDTH];
`else
  assign in_entry  = in_data_i;
`endif

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q[DATA_WIDTH-1:0];
  assign in_hs       = in_valid_i & ~skid_valid_q;
  assign out_hs      = main_valid_q & out_ready_i;
  assign out_hs_o    = out_hs;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    // Flush only clears valid bits; data registers hold their contents.
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_hs) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_hs) begin
        main_d = in_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      if (!main_valid_q) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  a_skid_implies_main: assert property (@(posedge i_clk) disable iff (i_arst)
    skid_valid_q |-> main_valid_q);

endmodule

// File: rtl/register_pipe.sv
// Elastic pipeline of DEPTH skid stages with flush and occupancy count.
// Define REGISTER_PIPE_PARITY_EN to carry and check a per-entry parity bit.
module register_pipe
  import register_pipe_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned DEPTH      = 2,
  localparam int unsigned CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_parity_err
);

  // Index k is the input side of stage k; index DEPTH is the pipeline output.
  logic [DEPTH:0]          st_valid;
  logic [DEPTH:0]          st_ready;
  logic [DATA_WIDTH-1:0]   st_data [DEPTH+1];
`ifdef REGISTER_PIPE_PARITY_EN
  logic [DEPTH:0]          st_par;
  logic [PARITY_MAX_W-1:0] in_data_ext;
`endif
  logic                    last_hs;
  logic                    in_hs;
  logic [CNT_WIDTH-1:0]    count_q, count_d;

  assign st_valid[0]     = i_valid;
  assign st_data[0]      = i_data;
  assign st_ready[DEPTH] = i_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic hs;

    register_skid #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .i_clk       (i_clk),
      .i_arst      (i_arst),
      .flush_i     (i_flush),
      .in_valid_i  (st_valid[k]),
      .in_ready_o  (st_ready[k]),
      .in_data_i   (st_data[k]),
`ifdef REGISTER_PIPE_PARITY_EN
      .in_par_i    (st_par[k]),
      .out_par_o   (st_par[k+1]),
`endif
      .out_valid_o (st_valid[k+1]),
      .out_ready_i (st_ready[k+1]),
      .out_data_o  (st_data[k+1]),
      .out_hs_o    (hs)
    );

    if (k == DEPTH - 1) begin : g_last
      assign last_hs = hs;
    end else begin : g_mid
      logic unused_hs;
      assign unused_hs = hs;
    end
  end

  assign o_ready = st_ready[0];
  assign o_valid = st_valid[DEPTH];
  assign o_data  = st_data[DEPTH];

`ifdef REGISTER_PIPE_PARITY_EN
  always_comb begin
    in_data_ext                 = '0;
    in_data_ext[DATA_WIDTH-1:0] = i_data;
  end
  assign st_par[0]    = even_parity(in_data_ext);
  assign o_parity_err = o_valid & (^o_data ^ st_par[DEPTH]);
`else
  assign o_parity_err = 1'b0;
`endif

  // Occupancy tracks boundary handshakes only; internal stage moves preserve it.
  assign in_hs = i_valid & o_ready;

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (in_hs && !last_hs) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (!in_hs && last_hs) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

  a_count_bound: assert property (@(posedge i_clk) disable iff (i_arst)
    count_q <= CNT_WIDTH'(2 * DEPTH));

endmodule

// File: tb/tb_register_pipe.sv
// Randomised bench for register_pipe against a FIFO-of-capacity-2*DEPTH model.
module tb_register_pipe;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(2 * DEPTH + 1);
  localparam int unsigned CAP   = 2 * DEPTH;

  logic          clk;
  logic          i_arst;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
  logic          o_parity_err;

  int checks;
  int failures;

  logic [DW-1:0] q[$];

  register_pipe #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_arst       (i_arst),
    .i_flush      (i_flush),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_count      (o_count),
    .o_parity_err (o_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle from a negedge; the model applies the edge's handshakes.
  task automatic apply(input logic v, input logic [DW-1:0] d, input logic r, input logic f,
                       output logic in_hs, output logic out_hs,
                       output logic [DW-1:0] exp_head, output logic [DW-1:0] got_head);
    i_valid  = v;
    i_data   = d;
    i_ready  = r;
    i_flush  = f;
    in_hs    = v & o_ready;
    out_hs   = o_valid & r;
    got_head = o_data;
    exp_head = (q.size() > 0) ? q[0] : '0;
    if (out_hs && q.size() > 0) void'(q.pop_front());
    if (f) q.delete();
    else if (in_hs) q.push_back(d);
    @(negedge clk);
  endtask

  task automatic test_reset;
    i_arst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    repeat (2) @(negedge clk);
    i_arst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL reset_data: got %0h expected 0", o_data); end
    checks++; if (o_count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity: got %b expected 0", o_parity_err); end
  endtask

  task automatic test_stream;
    logic ih, oh;
    logic [DW-1:0] exp, got;
    int pushed, outs, first_acc, first_out;
    pushed = 0; outs = 0; first_acc = -1; first_out = -1;
    for (int j = 0; j < 100 && outs < 16; j++) begin
      if (o_valid && first_out < 0) first_out = j;
      checks++; if (o_count > CW'(DEPTH)) begin failures++; $display("FAIL stream_count: got %0d expected <=%0d", o_count, DEPTH); end
      if (first_out >= 0) begin
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL stream_gap: got %b expected 1 at cycle %0d", o_valid, j); end
      end
      apply(pushed < 16, DW'(pushed + 1), 1'b1, 1'b0, ih, oh, exp, got);
      if (ih) begin
        if (first_acc < 0) first_acc = j;
        pushed++;
      end
      if (oh) begin
        outs++;
        checks++; if (got !== exp) begin failures++; $display("FAIL stream_data: got %0h expected %0h", got, exp); end
      end
    end
    checks++; if (outs != 16) begin failures++; $display("FAIL stream_outs: got %0d expected 16", outs); end
    checks++; if (first_out - first_acc != int'(DEPTH)) begin
      failures++; $display("FAIL stream_latency: got %0d expected %0d", first_out - first_acc, DEPTH);
    end
  endtask

  task automatic test_stall;
    logic ih, oh;
    logic [DW-1:0] exp, got;
    int acc, outs;
    acc = 0; outs = 0;
    for (int j = 0; j < 12; j++) begin
      apply(1'b1, DW'(32'h100 + j), 1'b0, 1'b0, ih, oh, exp, got);
      if (ih) acc++;
    end
    checks++; if (acc != int'(CAP)) begin failures++; $display("FAIL stall_accepted: got %0d expected %0d", acc, CAP); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b expected 0", o_ready); end
    checks++; if (o_count !== CW'(CAP)) begin failures++; $display("FAIL stall_count: got %0d expected %0d", o_count, CAP); end
    for (int j = 0; j < 20 && q.size() > 0; j++) begin
      apply(1'b0, '0, 1'b1, 1'b0, ih, oh, exp, got);
      if (oh) begin
        outs++;
        checks++; if (got !== exp) begin failures++; $display("FAIL stall_drain_data: got %0h expected %0h", got, exp); end
      end
    end
    checks++; if (outs != int'(CAP)) begin failures++; $display("FAIL stall_drain_count: got %0d expected %0d", outs, CAP); end
    checks++; if (o_count !== '0) begin failures++; $display("FAIL stall_empty: got %0d expected 0", o_count); end
  endtask

  task automatic test_random;
    logic ih, oh;
    logic [DW-1:0] exp, got;
    int vp, rp;
    vp = 2; rp = 2;
    for (int j = 0; j < 10000; j++) begin
      if (j % 500 == 0) begin vp = $urandom_range(1, 4); rp = $urandom_range(1, 4); end
      checks++; if (o_count !== CW'(q.size())) begin failures++; $display("FAIL rand_count: got %0d expected %0d cycle %0d", o_count, q.size(), j); end
      checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL rand_parity: got %b expected 0", o_parity_err); end
      if (o_valid) begin
        checks++; if (q.size() == 0) begin failures++; $display("FAIL rand_phantom: got o_valid=1 expected empty pipe"); end
      end
      if (q.size() == CAP) begin
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rand_full_ready: got %b expected 0", o_ready); end
      end
      apply($urandom_range(0, 4) < vp, {$urandom, $urandom}, $urandom_range(0, 4) < rp,
            $urandom_range(0, 127) == 0, ih, oh, exp, got);
      if (oh) begin
        checks++; if (got !== exp) begin failures++; $display("FAIL rand_data: got %0h expected %0h cycle %0d", got, exp, j); end
      end
    end
    for (int j = 0; j < 40 && q.size() > 0; j++) begin
      apply(1'b0, '0, 1'b1, 1'b0, ih, oh, exp, got);
      if (oh) begin
        checks++; if (got !== exp) begin failures++; $display("FAIL rand_drain_data: got %0h expected %0h", got, exp); end
      end
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_drain: got %0d left expected 0", q.size()); end
    checks++; if (o_count !== '0) begin failures++; $display("FAIL rand_drain_count: got %0d expected 0", o_count); end
  endtask

  task automatic test_flush;
    logic ih, oh;
    logic [DW-1:0] exp, got;
    bit seen;
    for (int j = 0; j < 3; j++) apply(1'b1, DW'(32'hA1 + j), 1'b0, 1'b0, ih, oh, exp, got);
    checks++; if (o_count !== CW'(3)) begin failures++; $display("FAIL flush_fill: got %0d expected 3", o_count); end
    apply(1'b1, DW'(32'hBB), 1'b0, 1'b1, ih, oh, exp, got);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", o_valid); end
    checks++; if (o_count !== '0) begin failures++; $display("FAIL flush_count: got %0d expected 0", o_count); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b expected 1", o_ready); end
    apply(1'b1, DW'(32'hAA), 1'b1, 1'b0, ih, oh, exp, got);
    seen = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      apply(1'b0, '0, 1'b1, 1'b0, ih, oh, exp, got);
      if (oh) begin
        seen = 1'b1;
        checks++; if (got !== DW'(32'hAA)) begin failures++; $display("FAIL flush_next: got %0h expected aa", got); end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL flush_timeout: got no output expected aa"); end
    // Output handshake completing in the flush cycle.
    for (int j = 0; j < 3; j++) apply(1'b1, DW'(32'hC1 + j), 1'b0, 1'b0, ih, oh, exp, got);
    apply(1'b1, DW'(32'hDD), 1'b1, 1'b1, ih, oh, exp, got);
    checks++; if (!oh || got !== DW'(32'hC1)) begin failures++; $display("FAIL flush_out_hs: got hs=%b data=%0h expected hs=1 data=c1", oh, got); end
    checks++; if (o_count !== '0 || o_valid !== 1'b0) begin failures++; $display("FAIL flush_out_state: got count=%0d valid=%b expected 0/0", o_count, o_valid); end
  endtask

  task automatic test_reset_mid;
    logic ih, oh;
    logic [DW-1:0] exp, got;
    for (int j = 0; j < 4; j++) apply(1'b1, DW'(32'hE1 + j), 1'b0, 1'b0, ih, oh, exp, got);
    i_valid = 1'b0;
    #2 i_arst = 1'b1;
    #1;
    q.delete();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL arst_valid: got %b expected 0", o_valid); end
    checks++; if (o_count !== '0) begin failures++; $display("FAIL arst_count: got %0d expected 0", o_count); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL arst_ready: got %b expected 1", o_ready); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL arst_data: got %0h expected 0", o_data); end
    i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    checks++; if (o_count !== '0 || o_valid !== 1'b0) begin failures++; $display("FAIL arst_hold: got count=%0d valid=%b expected 0/0", o_count, o_valid); end
    i_valid = 1'b0;
    i_arst  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_parity;
`ifdef REGISTER_PIPE_PARITY_EN
    logic ih, oh;
    logic [DW-1:0] exp, got;
    apply(1'b1, '0, 1'b0, 1'b0, ih, oh, exp, got);
    for (int j = 0; j < 10 && !o_valid; j++) apply(1'b0, '0, 1'b0, 1'b0, ih, oh, exp, got);
    checks++; if (o_valid !== 1'b1 || o_parity_err !== 1'b0) begin failures++; $display("FAIL parity_clean: got valid=%b err=%b expected 1/0", o_valid, o_parity_err); end
    force dut.g_stage[1].u_stage.main_q[0] = 1'b1;
    #1;
    checks++; if (o_parity_err !== 1'b1) begin failures++; $display("FAIL parity_err: got %b expected 1", o_parity_err); end
    release dut.g_stage[1].u_stage.main_q[0];
    apply(1'b0, '0, 1'b0, 1'b1, ih, oh, exp, got);
    checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL parity_flushed: got %b expected 0", o_parity_err); end
`else
    logic ih, oh;
    logic [DW-1:0] exp, got;
    apply(1'b1, DW'(1), 1'b0, 1'b0, ih, oh, exp, got);
    for (int j = 0; j < 10 && !o_valid; j++) apply(1'b0, '0, 1'b0, 1'b0, ih, oh, exp, got);
    checks++; if (o_valid !== 1'b1 || o_parity_err !== 1'b0) begin failures++; $display("FAIL parity_off: got valid=%b err=%b expected 1/0", o_valid, o_parity_err); end
    apply(1'b0, '0, 1'b0, 1'b1, ih, oh, exp, got);
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
